// File: rtl/uart_loader_pkg.sv
// Shared types for the UART boot loader: parser state encoding and the default sync marker.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    LEN   = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    CSUM  = 3'd5
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_loader.sv
// Serial boot loader: parses SYNC/ADDR/LEN/DATA/CSUM packets from the RX queue and
// writes 32-bit words to memory while holding the core in reset.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_empty_i,
  output logic        rx_re_o,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        busy_o,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Handshakes: rx_re_o pops the head byte in the same cycle it is sampled; a memory
  // write completes on any clock edge where mem_valid_o && mem_ready_i, and
  // mem_valid_o/mem_addr_o/mem_wdata_o stay stable until then.

  state_e      state_q, state_n;
  logic [31:0] addr_q;
  logic [31:0] word_q;
  logic [15:0] remain_q;
  logic [1:0]  idx_q;
  logic [7:0]  sum_q;
  logic [TW-1:0] tmo_q;
  logic        cpu_rst_q, done_q, error_q;

  logic        take, timed, timeout, done_n, error_n;
  logic [7:0]  csum_total;

  always_comb begin
    take       = !rst_i && (state_q != WRITE) && !rx_empty_i;
    timed      = (state_q == ADDR) || (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    timeout    = timed && rx_empty_i && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    csum_total = sum_q + rx_data_i;
    state_n    = state_q;
    done_n     = 1'b0;
    error_n    = 1'b0;
    case (state_q)
      IDLE:  if (take && rx_data_i == SYNC_BYTE) state_n = ADDR;
      ADDR:  if (take && idx_q == 2'd3) state_n = LEN;
      LEN:   if (take && idx_q[0])
               state_n = ({rx_data_i, remain_q[15:8]} == 16'd0) ? CSUM : DATA;
      DATA:  if (take && idx_q == 2'd3) state_n = WRITE;
      WRITE: if (mem_ready_i) state_n = (remain_q == 16'd1) ? CSUM : DATA;
      CSUM:  if (take) begin
               state_n = IDLE;
               done_n  = (csum_total == 8'h00);
               error_n = (csum_total != 8'h00);
             end
      default: state_n = IDLE;
    endcase
    if (timeout) begin
      state_n = IDLE;
      error_n = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      word_q    <= '0;
      remain_q  <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      tmo_q     <= '0;
      cpu_rst_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      cpu_rst_q <= (state_n != IDLE);
      done_q    <= done_n;
      error_q   <= error_n;
      // Counts only consecutive empty cycles inside a packet; any pop clears it.
      if (timed && rx_empty_i && !timeout) tmo_q <= tmo_q + 1'b1;
      else                                 tmo_q <= '0;
      if (take) begin
        idx_q <= (state_n == state_q) ? idx_q + 2'd1 : 2'd0;
        sum_q <= (state_q == IDLE) ? 8'h00 : csum_total;
        case (state_q)
          ADDR:    addr_q   <= {rx_data_i, addr_q[31:8]};
          LEN:     remain_q <= {rx_data_i, remain_q[15:8]};
          DATA:    word_q   <= {rx_data_i, word_q[31:8]};
          default: ;
        endcase
      end
      if (state_q == IDLE) begin
        sum_q <= 8'h00;
        idx_q <= 2'd0;
      end
      if (state_q == WRITE && mem_ready_i) begin
        addr_q   <= addr_q + 32'd4;
        remain_q <= remain_q - 16'd1;
      end
    end
  end

  assign rx_re_o     = take;
  assign mem_valid_o = (state_q == WRITE);
  assign mem_addr_o  = {addr_q[31:2], 2'b00};
  assign mem_wdata_o = word_q;
  assign busy_o      = (state_q != IDLE);
  assign cpu_rst_o   = cpu_rst_q;
  assign done_o      = done_q;
  assign error_o     = error_q;

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Serial boot loader that sits directly downstream of the UART receive block.
- It drains received bytes from the RX queue and parses a framed load packet.
- It writes the payload as 32-bit words into instruction/data memory over a valid/ready write port.
- It holds the core in reset while a load is in progress, and reports completion or failure.

Parameters:
- SYNC_BYTE, 8'hA5: packet start marker.
- TIMEOUT_CYCLES, 1_000_000: maximum idle clocks between bytes inside a packet before aborting.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous, active-high reset.
- rx_data_i  input  8  byte at the head of the RX queue (combinational from the RX block).
- rx_empty_i  input  1  RX queue empty.
- rx_re_o  output  1  one-cycle pop strobe to the RX queue.
- mem_valid_o  output  1  write request valid.
- mem_ready_i  input  1  memory accepts the write this cycle.
- mem_addr_o  output  32  word-aligned write address.
- mem_wdata_o  output  32  write data.
- busy_o  output  1  packet in progress.
- cpu_rst_o  output  1  core reset request.
- done_o  output  1  one-cycle pulse: packet accepted, checksum good.
- error_o  output  1  one-cycle pulse: checksum bad or timeout.

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-high on rst_i.
  - Reset values: all outputs 0, state IDLE, counters 0.
  - Reset mid-packet abandons the packet; mem_valid_o drops at the next edge and no pulse is issued.
- Packet format, all multi-byte fields little-endian: SYNC, ADDR[4], LEN[2] (word count), DATA[LEN*4], CSUM[1].
- Checksum rule: the 8-bit sum of every byte after SYNC, CSUM included, must be 8'h00.
- Byte consume rule:
  - In a byte-accepting state with rx_empty_i=0, the byte is sampled from rx_data_i and rx_re_o=1 in the same cycle.
  - Maximum rate is one byte per clock.
  - rx_re_o is never asserted while rx_empty_i=1 or in WRITE.
- State machine (states IDLE, ADDR, LEN, DATA, WRITE, CSUM):
  - IDLE: a byte == SYNC_BYTE goes to ADDR; any other byte is popped and discarded. Sum clears and byte index is 0.
  - ADDR: 4 bytes go into the address register, then LEN.
  - LEN: 2 bytes go into a 16-bit word count. After the 2nd byte, go to CSUM if the count is 0, else DATA.
  - DATA: 4 bytes go into a word shift register. On the 4th byte go to WRITE with mem_valid_o=1 from the next cycle.
  - WRITE:
    - mem_valid_o, mem_addr_o and mem_wdata_o are held stable until mem_ready_i=1.
    - On acceptance: address += 4 (32-bit wrap) and remaining count -= 1.
    - Next state is CSUM if remaining == 0, else DATA.
    - A same-cycle ready with valid is accepted.
  - CSUM: pop 1 byte, return to IDLE. Pulse done_o if (sum + byte) == 0, else pulse error_o.
- Address: mem_addr_o = {addr[31:2], 2'b00}; low address bits from the packet are ignored.
- Memory ordering: writes are issued as each word completes, not deferred to checksum. A bad checksum still leaves the data written; error_o flags it.
- Timeout:
  - The counter runs only in ADDR/LEN/DATA/CSUM while rx_empty_i=1 and clears on every consumed byte.
  - Reaching TIMEOUT_CYCLES goes to IDLE and pulses error_o.
  - No timeout accrues in WRITE, where memory backpressure is unbounded.
- Status outputs:
  - busy_o = (state != IDLE).
  - cpu_rst_o registered: set on leaving IDLE, cleared when returning to IDLE.
  - done_o and error_o are mutually exclusive.
- Width rules:
  - Timeout counter is $clog2(TIMEOUT_CYCLES+1) bits.
  - Word count is 16 bits, so up to 65535 words (256 KiB) per packet.

Decomposition:
- Package uart_loader_pkg: state enum (IDLE, ADDR, LEN, DATA, WRITE, CSUM) and the default SYNC_BYTE constant.
- No sub-module: byte assembly, checksum and timeout are small enough to live in the single module.

Test Plan:
- Good packet A5 00 10 00 00 02 00 EF BE AD DE 78 56 34 12 A2, mem_ready_i=1 -> write 0x00001000=0xDEADBEEF, write 0x00001004=0x12345678, done_o pulse, busy_o/cpu_rst_o low afterwards.
- Same packet with CSUM=A3 -> both writes still issued, error_o pulse, no done_o.
- Bytes 00 FF 13 before the good packet -> garbage popped in IDLE, result identical to the good-packet case.
- mem_ready_i held low 10 cycles on the first write -> mem_valid_o/addr/data stable, rx_re_o=0 throughout, no timeout, completes normally.
- TIMEOUT_CYCLES=100, stream stops after the LEN bytes -> error_o exactly 100 idle cycles after the last pop, state IDLE.
- LEN=0 packet A5 00 20 00 00 00 00 E0 -> no memory writes, done_o pulse; rst_i pulsed mid-DATA on another packet -> all outputs 0 next cycle, no pulse.
